rx_dest_drain: RTL
==================

// Module: rx_dest_drain
// PURPOSE
//  Receive-side consumer of the transmitter's two destination FIFOs (D0, D1).
//  - Pops words round-robin whenever a source FIFO is non-empty and local space exists.
//  - Buffers the words locally and presents them on a valid/ready output.
//  - Throttles itself against a programmable almost-full threshold; keeps per-source receive counts.
// PARAMETERS
//  DATA_W  6  word width, matches transmitter D0/D1 data width
//  DEPTH   8  local buffer depth in words, power of two
//  CNT_W   5  width of thresholds and per-source counters
// PORTS
//  clk           in   1       clock, all logic on posedge
//  RESET_L       in   1       synchronous active-low reset
//  init          in   1       threshold load / hold-off request
//  rx_high       in   CNT_W   almost-full threshold, captured while in INIT with init=1
//  D0_EMPTY      in   1       source FIFO D0 empty
//  D1_EMPTY      in   1       source FIFO D1 empty
//  D0_DATA_OUT   in   DATA_W  D0 read data, valid 1 cycle after POP_D0
//  D1_DATA_OUT   in   DATA_W  D1 read data, valid 1 cycle after POP_D1
//  POP_D0        out  1       pop strobe to D0
//  POP_D1        out  1       pop strobe to D1
//  DATA_OUT_RX   out  DATA_W  head of local buffer
//  VALID_OUT_RX  out  1       DATA_OUT_RX valid
//  READY_IN_RX   in   1       downstream accepts; transfer = VALID & READY
//  rx_almost_full out 1       occupancy >= effective threshold
//  cnt_d0        out  CNT_W   words received from D0
//  cnt_d1        out  CNT_W   words received from D1
//  idle          out  1       state IDLE, buffer empty, nothing in flight
// BEHAVIOUR
//  - Reset (RESET_L=0 at posedge): all outputs 0; state RESET; buffer, in-flight flag, RR pointer (->D0) cleared.
//  - FSM: RESET -> INIT (first cycle RESET_L=1).
//    - INIT: latch rx_high every cycle init=1; go to IDLE when init=0.
//    - IDLE: go to ACTIVE when either EMPTY=0.
//    - ACTIVE: go to IDLE when both EMPTY=1 and nothing in flight; go to INIT when init=1 (in-flight word still captured).
//  - Pops: registered, at most one of POP_D0/POP_D1 per cycle.
//    - Issued only in ACTIVE when the selected source is non-empty and occ+inflight < thr_eff.
//    - RR: prefer the source not served last; if it is empty, serve the other.
//    - A source with EMPTY=1 is never popped.
//  - Capture: data sampled 1 cycle after the pop cycle and written to the buffer; the source counter increments.
//  - thr_eff = DEPTH when rx_high==0 or rx_high>DEPTH, else rx_high.
//  - Occupancy: simultaneous write and read leaves occ unchanged; occ never exceeds DEPTH; no write when full.
//  - VALID_OUT_RX = occ!=0. DATA_OUT_RX is combinational from the head and holds while READY_IN_RX=0.
//  - Counters wrap modulo 2^CNT_W.
//  - rx_almost_full is registered; it updates the cycle after occ changes.
// CONFIGURATION
//  RX_STATS_EN
//    - defined: cnt_d0/cnt_d1 counters implemented as above.
//    - undefined: counters not built, cnt_d0/cnt_d1 tied to 0.
// STRUCTURE
//  Shared package rx_defs:
//    - FSM state encodings RESET/INIT/IDLE/ACTIVE.
//    - SRC_D0/SRC_D1 constants.
//    - Default DATA_W/CNT_W.
//  Sub-module rx_sync_fifo: DEPTH x DATA_W, registered pointers, occ output, full/empty.
// TESTING
//  1. Reset for 2 cycles -> all outputs 0. Release with init=1, rx_high=3, then init=0 -> IDLE, idle=1.
//  2. D0 holds 6'b001010 -> single POP_D0 pulse. Two cycles later DATA_OUT_RX=6'b001010, VALID=1, cnt_d0=1.
//  3. D0 and D1 both non-empty, READY_IN_RX=1 -> POP_D0,POP_D1,POP_D0,... alternating; D1 word 6'b111110 delivered, cnt_d1=1.
//  4. READY_IN_RX=0, rx_high=3, sources full -> exactly 3 pops, rx_almost_full=1. READY=1 for one cycle -> 1 more pop.
//  5. rx_high=0, READY=0 -> exactly 8 pops (DEPTH) and no more; no overflow, occ=8.
//  6. RESET_L=0 the cycle after a POP_D1 -> word discarded, VALID=0, counters 0, state RESET.

Source files
------------

// File: rtl/rx_defs.sv
// Shared definitions for the receive-side destination drain: FSM states,
// source identifiers and default widths.
package rx_defs;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_CNT_W  = 5;
  localparam int DEF_DEPTH  = 8;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock DEPTH x DATA_W buffer with registered pointers and an
// occupancy count; writes when full and reads when empty are ignored.
module rx_sync_fifo
  import rx_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ_q;
  logic              wr_ok, rd_ok;

  assign full    = (occ_q == (AW+1)'(DEPTH));
  assign empty   = (occ_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign occ     = occ_q;

  // NOTE: non-blocking assignments keep every register update in this edge
  // based on pre-edge values, so ordering between statements cannot matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy qualifies every read,
  // and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rx_dest_drain.sv
// Round-robin drain of the D0/D1 destination FIFOs into a local buffer with a
// valid/ready output. Define RX_STATS_EN to build the per-source receive counters.
module rx_dest_drain
  import rx_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              init,
  input  logic [CNT_W-1:0]  rx_high,
  input  logic              D0_EMPTY,
  input  logic              D1_EMPTY,
  input  logic [DATA_W-1:0] D0_DATA_OUT,
  input  logic [DATA_W-1:0] D1_DATA_OUT,
  output logic              POP_D0,
  output logic              POP_D1,
  output logic [DATA_W-1:0] DATA_OUT_RX,
  output logic              VALID_OUT_RX,
  input  logic              READY_IN_RX,
  output logic              rx_almost_full,
  output logic [CNT_W-1:0]  cnt_d0,
  output logic [CNT_W-1:0]  cnt_d1,
  output logic              idle
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMP_W = ((CNT_W > AW + 1) ? CNT_W : AW + 1) + 2;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  thr_q;
  logic              pop0_q, pop1_q, pop0_d, pop1_d;
  logic              cap_v_q, cap_src_q;
  logic              rr_q;
  logic              af_q;
  logic              in_flight, avail0, avail1;
  logic [CMP_W-1:0]  thr_eff, pending;
  logic [AW:0]       occ;
  logic              full, empty;
  logic [DATA_W-1:0] head, wr_data;

  rx_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (RESET_L),
    .wr_en   (cap_v_q && !full),
    .wr_data (wr_data),
    .rd_en   (VALID_OUT_RX && READY_IN_RX),
    .rd_data (head),
    .occ     (occ),
    .full    (full),
    .empty   (empty)
  );

  assign wr_data   = (cap_src_q == SRC_D1) ? D1_DATA_OUT : D0_DATA_OUT;
  assign in_flight = pop0_q | pop1_q | cap_v_q;
  // A source popped this cycle still shows its pre-pop EMPTY, so skip it once.
  assign avail0    = !D0_EMPTY && !pop0_q;
  assign avail1    = !D1_EMPTY && !pop1_q;
  assign pending   = CMP_W'(occ) + CMP_W'(pop0_q | pop1_q) + CMP_W'(cap_v_q);

  always_comb begin
    if (thr_q == '0 || CMP_W'(thr_q) > CMP_W'(DEPTH)) thr_eff = CMP_W'(DEPTH);
    else                                              thr_eff = CMP_W'(thr_q);
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    pop0_d  = 1'b0;
    pop1_d  = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!init) state_d = ST_IDLE;
      ST_IDLE:  if (!D0_EMPTY || !D1_EMPTY) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (D0_EMPTY && D1_EMPTY && !in_flight) begin
          state_d = ST_IDLE;
        end else if (pending < thr_eff) begin
          if (rr_q == SRC_D0) begin
            if (avail0)      pop0_d = 1'b1;
            else if (avail1) pop1_d = 1'b1;
          end else begin
            if (avail1)      pop1_d = 1'b1;
            else if (avail0) pop0_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state_q   <= ST_RESET;
      thr_q     <= '0;
      pop0_q    <= 1'b0;
      pop1_q    <= 1'b0;
      cap_v_q   <= 1'b0;
      cap_src_q <= SRC_D0;
      rr_q      <= SRC_D0;
      af_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == ST_INIT && init) thr_q <= rx_high;
      pop0_q    <= pop0_d;
      pop1_q    <= pop1_d;
      cap_v_q   <= pop0_q | pop1_q;
      cap_src_q <= pop1_q ? SRC_D1 : SRC_D0;
      if (pop0_d)      rr_q <= SRC_D1;
      else if (pop1_d) rr_q <= SRC_D0;
      af_q      <= (CMP_W'(occ) >= thr_eff);
    end
  end

`ifdef RX_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (cap_v_q) begin
      if (cap_src_q == SRC_D1) cnt1_q <= cnt1_q + 1'b1;
      else                     cnt0_q <= cnt0_q + 1'b1;
    end
  end

  assign cnt_d0 = cnt0_q;
  assign cnt_d1 = cnt1_q;
`else
  assign cnt_d0 = '0;
  assign cnt_d1 = '0;
`endif

  assign POP_D0         = pop0_q;
  assign POP_D1         = pop1_q;
  assign VALID_OUT_RX   = !empty;
  assign DATA_OUT_RX    = empty ? '0 : head;
  assign rx_almost_full = af_q;
  assign idle           = (state_q == ST_IDLE) && empty && !in_flight;

endmodule
